// File: rtl/axi_led_pkg.sv
// axi_led_pkg
// Shared definitions for the AXI4-Lite LED pattern controller:
//   - register byte offsets (word aligned, addr[1:0] ignored)
//   - per-LED mode encoding
//   - write/read channel FSM state types
//   - AXI response code
package axi_led_pkg;

  localparam logic [4:0] OFF_VALUE     = 5'h00;
  localparam logic [4:0] OFF_MODE      = 5'h04;
  localparam logic [4:0] OFF_BLINK_DIV = 5'h08;
  localparam logic [4:0] OFF_DUTY      = 5'h0C;
  localparam logic [4:0] OFF_STATUS    = 5'h10;

  // Mask that drops the byte-within-word bits of an address.
  localparam logic [4:0] WORD_MASK = 5'h1C;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_OFF    = 2'b11
  } led_mode_e;

  typedef enum logic [1:0] {
    W_IDLE    = 2'b00,
    W_HAVE_AW = 2'b01,
    W_HAVE_W  = 2'b10,
    W_RESP    = 2'b11
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_led_pattern_ctrl_led_pattern_gen.sv
// led_pattern_gen
// Blink and PWM timebases plus the registered per-LED output mux.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   value            : static level per LED
//   mode             : 2 bits per LED (static / blink / PWM / off)
//   blink_div        : blink half-period in clocks (0 behaves as 1)
//   duty             : 8-bit PWM duty per LED
//   blink_div_wr     : one-cycle pulse on the edge BLINK_DIV is written
//   leds             : registered LED drive
//   blink_phase      : current blink phase
module led_pattern_gen
  import axi_led_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int PWM_PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LEDS-1:0]   value,
  input  logic [2*NUM_LEDS-1:0] mode,
  input  logic [31:0]           blink_div,
  input  logic [8*NUM_LEDS-1:0] duty,
  input  logic                  blink_div_wr,
  output logic [NUM_LEDS-1:0]   leds,
  output logic                  blink_phase
);

  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

  logic [31:0]         blink_cnt;
  logic [31:0]         blink_last;
  logic [PRE_W-1:0]    pre_cnt;
  logic [7:0]          pwm_cnt;
  logic [NUM_LEDS-1:0] led_next;

  // A divider of 0 is treated as 1, so the last count is 0 in both cases.
  assign blink_last = (blink_div == 32'd0) ? 32'd0 : (blink_div - 32'd1);

  // Blink timebase. The >= compare also recovers cleanly if the count is
  // ever above the limit, although a divider write always restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= 32'd0;
      blink_phase <= 1'b0;
    end else if (blink_div_wr) begin
      blink_cnt   <= 32'd0;
      blink_phase <= 1'b0;
    end else if (blink_cnt >= blink_last) begin
      blink_cnt   <= 32'd0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 32'd1;
    end
  end

  // PWM timebase: pwm_cnt steps once every PWM_PRESCALE clocks, wraps 255->0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'd0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (led_mode_e'(mode[2*i +: 2]))
        MODE_STATIC: led_next[i] = value[i];
        MODE_BLINK:  led_next[i] = value[i] & blink_phase;
        MODE_PWM:    led_next[i] = (pwm_cnt < duty[8*i +: 8]);
        default:     led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds <= '0;
    end else begin
      leds <= led_next;
    end
  end

endmodule

// File: rtl/axi_led_pattern_ctrl.sv
// axi_led_pattern_ctrl
// AXI4-Lite slave that programs four LEDs as static, blinking, PWM-dimmed
// or forced off.
// Handshake rule on every channel: a transfer happens on a rising edge
// where both valid and ready are 1; valid, once raised, holds with its
// payload stable until that edge.
// Ports:
//   aclk, areset          : clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w*  : write address / write data channels
//   s_axi_b*              : write response (always OKAY)
//   s_axi_ar* / s_axi_r*  : read address / read data (always OKAY)
//   led_4bits_tri_o       : registered LED drive
module axi_led_pattern_ctrl
  import axi_led_pkg::*;
#(
  parameter int          ADDR_W       = 5,
  parameter int          NUM_LEDS     = 4,
  parameter int          PWM_PRESCALE = 1,
  parameter logic [15:0] VERSION      = 16'h0100
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [3:0]        led_4bits_tri_o
);

  w_state_e w_state;
  r_state_e r_state;

  logic [4:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic [3:0]  value_q;
  logic [7:0]  mode_q;
  logic [31:0] blink_div_q;
  logic [31:0] duty_q;
  logic        blink_phase;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] wr_old;
  logic [31:0] wr_merged;
  logic        blink_div_wr;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;

  // Register view as software sees it; unused bits and holes read as 0.
  function automatic logic [31:0] reg_read(
    input logic [4:0]  a,
    input logic [3:0]  value,
    input logic [7:0]  mode,
    input logic [31:0] div,
    input logic [31:0] duty,
    input logic        phase
  );
    logic [31:0] d;
    d = 32'd0;
    case (a & WORD_MASK)
      OFF_VALUE:     d = {28'd0, value};
      OFF_MODE:      d = {24'd0, mode};
      OFF_BLINK_DIV: d = div;
      OFF_DUTY:      d = duty;
      OFF_STATUS:    d = {VERSION, 15'd0, phase};
      default:       d = 32'd0;
    endcase
    return d;
  endfunction

  // Commit happens on the edge where the second of AW/W is accepted; the
  // half that arrived earlier comes from its holding register.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = aw_addr_q;
    wr_data = w_data_q;
    wr_strb = w_strb_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_en   = 1'b1;
          wr_addr = s_axi_awaddr[4:0];
          wr_data = s_axi_wdata;
          wr_strb = s_axi_wstrb;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          wr_en   = 1'b1;
          wr_data = s_axi_wdata;
          wr_strb = s_axi_wstrb;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          wr_en   = 1'b1;
          wr_addr = s_axi_awaddr[4:0];
        end
      end
      default: ;
    endcase
  end

  // Byte-enable merge against the current register contents.
  always_comb begin
    wr_old    = reg_read(wr_addr, value_q, mode_q, blink_div_q, duty_q, blink_phase);
    wr_merged = wr_old;
    for (int b = 0; b < 4; b++) begin
      if (wr_strb[b]) begin
        wr_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // A strobe-less write changes nothing, so it does not restart the blink.
  assign blink_div_wr = wr_en && ((wr_addr & WORD_MASK) == OFF_BLINK_DIV) && (|wr_strb);

  always_ff @(posedge aclk) begin
    if (areset) begin
      value_q     <= 4'd0;
      mode_q      <= 8'd0;
      blink_div_q <= 32'd0;
      duty_q      <= 32'd0;
    end else if (wr_en) begin
      case (wr_addr & WORD_MASK)
        OFF_VALUE:     value_q     <= wr_merged[3:0];
        OFF_MODE:      mode_q      <= wr_merged[7:0];
        OFF_BLINK_DIV: blink_div_q <= wr_merged;
        OFF_DUTY:      duty_q      <= wr_merged;
        default: ;
      endcase
    end
  end

  // Write channel FSM. Ready/valid outputs are registered alongside the
  // state, so they read 0 for the first cycle after reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      aw_addr_q     <= 5'd0;
      w_data_q      <= 32'd0;
      w_strb_q      <= 4'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state       <= W_RESP;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
          end else if (aw_hs) begin
            w_state       <= W_HAVE_AW;
            aw_addr_q     <= s_axi_awaddr[4:0];
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
          end else if (w_hs) begin
            w_state       <= W_HAVE_W;
            w_data_q      <= s_axi_wdata;
            w_strb_q      <= s_axi_wstrb;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
          end else begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        W_HAVE_AW: begin
          if (w_hs) begin
            w_state      <= W_RESP;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
          end
        end
        W_HAVE_W: begin
          if (aw_hs) begin
            w_state       <= W_RESP;
            s_axi_awready <= 1'b0;
            s_axi_bvalid  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state       <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM. rdata is sampled from the pre-edge registers, so a
  // read racing a write to the same register returns the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 32'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state       <= R_DATA;
            s_axi_rdata   <= reg_read(s_axi_araddr[4:0], value_q, mode_q,
                                      blink_div_q, duty_q, blink_phase);
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            r_state       <= R_IDLE;
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  led_pattern_gen #(
    .NUM_LEDS     (NUM_LEDS),
    .PWM_PRESCALE (PWM_PRESCALE)
  ) u_gen (
    .clk          (aclk),
    .rst          (areset),
    .value        (value_q),
    .mode         (mode_q),
    .blink_div    (blink_div_q),
    .duty         (duty_q),
    .blink_div_wr (blink_div_wr),
    .leds         (led_4bits_tri_o),
    .blink_phase  (blink_phase)
  );

endmodule

// File: tb/tb_axi_led_pattern_ctrl.sv
// tb_axi_led_pattern_ctrl
// Self-checking bench for axi_led_pattern_ctrl: directed scenarios plus
// randomized AXI traffic, checked every cycle against a behavioural model.
module tb_axi_led_pattern_ctrl;

  localparam int P = 1;

  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        areset;
  always #5 aclk = ~aclk;

  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb, led;
  logic [1:0]  bresp, rresp;

  axi_led_pattern_ctrl #(.ADDR_W(5), .NUM_LEDS(4), .PWM_PRESCALE(P), .VERSION(16'h0100)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .led_4bits_tri_o(led)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=handshake", name);
  endtask

  // ---------------- behavioural model ----------------
  // Registers as software sees them; blink phase and PWM count are derived
  // arithmetically from the number of edges since reset / last divider write.
  logic [3:0]  m_value;
  logic [7:0]  m_mode;
  logic [31:0] m_div, m_duty;
  int          k = 0;          // edges since reset
  int          c = 0;          // edge count at last blink restart
  bit          aw_seen = 0, w_seen = 0, b_out = 0, last_rst = 1;
  logic [4:0]  aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  logic [3:0]  exp_led = 4'd0, nxt_led;
  logic [31:0] exp_q[$];
  int          b_count = 0;

  initial begin
    m_value = 0; m_mode = 0; m_div = 0; m_duty = 0;
  end

  function automatic bit phase_now();
    longint unsigned d = (m_div == 0) ? 1 : longint'(m_div);
    return 1'(((longint'(k) - longint'(c)) / d) % 2);
  endfunction

  function automatic logic [7:0] pwm_now();
    return 8'((k / P) % 256);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (int'(a[4:2]))
      0: return {28'd0, m_value};
      1: return {24'd0, m_mode};
      2: return m_div;
      3: return m_duty;
      4: return {16'h0100, 15'd0, phase_now()};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] model_leds();
    logic [3:0] l;
    for (int i = 0; i < 4; i++) begin
      case (m_mode[2*i +: 2])
        2'b00:   l[i] = m_value[i];
        2'b01:   l[i] = m_value[i] & phase_now();
        2'b10:   l[i] = (pwm_now() < m_duty[8*i +: 8]);
        default: l[i] = 1'b0;
      endcase
    end
    return l;
  endfunction

  task automatic model_commit(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] nw;
    nw = model_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
    case (int'(a[4:2]))
      0: m_value = nw[3:0];
      1: m_mode  = nw[7:0];
      2: if (s != 0) begin m_div = nw; c = k + 1; end
      3: m_duty  = nw;
      default: ;
    endcase
  endtask

  // Snapshot of the bus taken mid-cycle, applied to the model on the edge.
  logic       sn_rst, sn_awv, sn_awr, sn_wv, sn_wr, sn_bv, sn_br, sn_arv, sn_arr, sn_rv, sn_rr;
  logic [4:0] sn_awaddr, sn_araddr;
  logic [31:0] sn_wdata;
  logic [3:0] sn_wstrb;

  // ---------------- compare process ----------------
  always begin
    @(negedge aclk);
    check("led", {28'd0, led}, {28'd0, exp_led});
    check("bvalid", 32'(bvalid), 32'(b_out));
    check("rvalid", 32'(rvalid), 32'(exp_q.size() != 0));
    check("awready", 32'(awready), 32'(!last_rst && !b_out && !aw_seen));
    check("wready", 32'(wready), 32'(!last_rst && !b_out && !w_seen));
    check("arready", 32'(arready), 32'(!last_rst && exp_q.size() == 0));
    if (b_out) check("bresp", 32'(bresp), 32'd0);
    if (exp_q.size() != 0) begin
      check("rdata", rdata, exp_q[0]);
      check("rresp", 32'(rresp), 32'd0);
    end
    #2;
    sn_rst = areset;
    sn_awv = awvalid; sn_awr = awready; sn_awaddr = awaddr;
    sn_wv = wvalid; sn_wr = wready; sn_wdata = wdata; sn_wstrb = wstrb;
    sn_bv = bvalid; sn_br = bready;
    sn_arv = arvalid; sn_arr = arready; sn_araddr = araddr;
    sn_rv = rvalid; sn_rr = rready;
    @(posedge aclk);
    if (sn_rst) begin
      m_value = 0; m_mode = 0; m_div = 0; m_duty = 0;
      k = 0; c = 0; aw_seen = 0; w_seen = 0; b_out = 0;
      exp_q.delete(); last_rst = 1; exp_led = 4'd0;
    end else begin
      nxt_led = model_leds();
      if (sn_arv && sn_arr) exp_q.push_back(model_read(sn_araddr));
      if (sn_rv && sn_rr && exp_q.size() != 0) void'(exp_q.pop_front());
      if (sn_bv && sn_br) begin b_out = 0; b_count++; end
      if (sn_awv && sn_awr) begin aw_seen = 1; aw_a = sn_awaddr; end
      if (sn_wv && sn_wr) begin w_seen = 1; w_d = sn_wdata; w_s = sn_wstrb; end
      if (aw_seen && w_seen) begin
        model_commit(aw_a, w_d, w_s);
        aw_seen = 0; w_seen = 0; b_out = 1;
      end
      k++;
      last_rst = 0;
      exp_led = nxt_led;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, input bit take_b);
    fork
      begin
        repeat (aw_dly) @(negedge aclk);
        awaddr = a; awvalid = 1'b1;
        for (int t = 0; t < 200 && !awready; t++) @(negedge aclk);
        if (!awready) timeout("aw_handshake");
        else @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge aclk);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int t = 0; t < 200 && !wready; t++) @(negedge aclk);
        if (!wready) timeout("w_handshake");
        else @(posedge aclk);
        @(negedge aclk);
        wvalid = 1'b0;
      end
    join
    if (take_b) begin
      repeat (b_dly) @(negedge aclk);
      bready = 1'b1;
      for (int t = 0; t < 200 && !bvalid; t++) @(negedge aclk);
      if (!bvalid) timeout("b_handshake");
      else @(posedge aclk);
      @(negedge aclk);
      bready = 1'b0;
    end else begin
      for (int t = 0; t < 200 && !bvalid; t++) @(negedge aclk);
      if (!bvalid) timeout("b_wait");
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input int r_dly, output logic [31:0] d);
    d = 32'hDEADBEEF;
    araddr = a; arvalid = 1'b1;
    for (int t = 0; t < 200 && !arready; t++) @(negedge aclk);
    if (!arready) timeout("ar_handshake");
    else @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    repeat (r_dly) @(negedge aclk);
    rready = 1'b1;
    for (int t = 0; t < 200 && !rvalid; t++) @(negedge aclk);
    if (!rvalid) timeout("r_handshake");
    else begin
      d = rdata;
      @(posedge aclk);
    end
    @(negedge aclk);
    rready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  int          bc, tg;
  int          on_cnt[4];
  logic        prev;

  initial begin
    areset = 1'b1;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge aclk);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    areset = 1'b0;
    @(negedge aclk);

    // Static VALUE write, all bytes enabled.
    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1);
    axi_read(5'h00, 0, rd);
    check("value_rd", rd, 32'h0000_000F);
    check("led_static", {28'd0, led}, 32'h0000_000F);

    // AW ahead of W by 3 cycles, B held off for 5 cycles.
    bc = b_count;
    axi_write(5'h00, 32'h0000_0005, 4'h1, 0, 3, 5, 1);
    check("b_once", 32'(b_count - bc), 32'd1);
    axi_read(5'h00, 2, rd);
    check("value_once", rd, 32'h0000_0005);

    // Blink LED0 with half-period 4.
    axi_write(5'h04, 32'h0000_0001, 4'hF, 0, 0, 0, 1);
    axi_write(5'h00, 32'h0000_0001, 4'hF, 1, 0, 0, 1);
    axi_write(5'h08, 32'd4, 4'hF, 0, 2, 0, 1);
    repeat (6) @(negedge aclk);
    tg = 0;
    prev = led[0];
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      if (led[0] != prev) tg++;
      prev = led[0];
    end
    check("blink_toggles", 32'(tg), 32'd4);
    check("blink_upper", {29'd0, led[3:1]}, 32'd0);

    // PWM duty window.
    axi_write(5'h0C, 32'hFF80_4000, 4'hF, 0, 0, 0, 1);
    axi_write(5'h04, 32'h0000_00AA, 4'hF, 0, 0, 0, 1);
    repeat (4) @(negedge aclk);
    for (int i = 0; i < 4; i++) on_cnt[i] = 0;
    for (int s = 0; s < 256; s++) begin
      @(negedge aclk);
      for (int i = 0; i < 4; i++) on_cnt[i] += int'(led[i]);
    end
    check("pwm_led0", 32'(on_cnt[0]), 32'd0);
    check("pwm_led1", 32'(on_cnt[1]), 32'd64);
    check("pwm_led2", 32'(on_cnt[2]), 32'd128);
    check("pwm_led3", 32'(on_cnt[3]), 32'd255);

    // Strobe-less write, holes and STATUS.
    axi_write(5'h04, 32'h0000_0055, 4'h0, 0, 0, 0, 1);
    axi_read(5'h04, 0, rd);
    check("mode_strb0", rd, 32'h0000_00AA);
    axi_write(5'h14, 32'h1234_5678, 4'hF, 0, 0, 0, 1);
    axi_read(5'h14, 0, rd);
    check("hole_14", rd, 32'd0);
    axi_read(5'h1C, 1, rd);
    check("hole_1c", rd, 32'd0);
    axi_read(5'h10, 0, rd);
    check("status_ver", {16'd0, rd[31:16]}, 32'h0000_0100);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = 5'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      if (a[4:2] == 3'd2) d = 32'($urandom_range(0, 9));
      else d = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1);
      else
        axi_read(a, $urandom_range(0, 3), rd);
      repeat ($urandom_range(0, 6)) @(negedge aclk);
    end

    // Reset while a B is pending and LEDs are blinking.
    axi_write(5'h04, 32'h0000_0055, 4'hF, 0, 0, 0, 1);
    axi_write(5'h00, 32'h0000_000F, 4'hF, 0, 0, 0, 1);
    axi_write(5'h08, 32'd2, 4'hF, 0, 0, 0, 1);
    repeat (5) @(negedge aclk);
    axi_write(5'h0C, 32'h0102_0304, 4'hF, 0, 0, 0, 0);
    check("pre_rst_bvalid", 32'(bvalid), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("post_rst_bvalid", 32'(bvalid), 32'd0);
    check("post_rst_led", {28'd0, led}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      axi_read(5'(r * 4), 0, rd);
      check("post_rst_reg", rd, 32'd0);
    end
    axi_read(5'h10, 0, rd);
    check("post_rst_status", {rd[31:1], 1'b0}, 32'h0100_0000);

    repeat (3) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_led_pattern_ctrl.md
Name: axi_led_pattern_ctrl

Overview:
AXI4-Lite slave on the PS general-purpose master port, downstream of the PS. It drives the board's 4-bit LED bus (led_4bits_tri_o) at the wrapper top level. Each LED is individually programmable as static, blinking, or 8-bit PWM-dimmed, so software can animate the LEDs without polling. Single clock domain on the PS-provided PL clock.

Parameters:
ADDR_W, 5, AXI address width; the slave decodes byte offsets 0x00-0x1F.
NUM_LEDS, 4, number of LED outputs; fixed at 4 by the register layout.
PWM_PRESCALE, 1, clocks per PWM counter step; must be >= 1.
VERSION, 16'h0100, value returned in STATUS[31:16].

Ports:
aclk  in  1  PL clock; all logic on the rising edge.
areset  in  1  synchronous reset, active-high.
s_axi_awaddr  in  ADDR_W  write address.
s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte enables.
s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake.
s_axi_bresp  out  2  write response; always 2'b00.
s_axi_bvalid / s_axi_bready  out/in  1  write-response handshake.
s_axi_araddr  in  ADDR_W  read address.
s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  read response; always 2'b00.
s_axi_rvalid / s_axi_rready  out/in  1  read-data handshake.
led_4bits_tri_o  out  4  LED drive, registered.

Behaviour:
- Clock and reset: one clock (aclk); reset (areset) is synchronous and active-high.
- Reset values: all registers 0; every ready/valid output 0; rdata 0; led_4bits_tri_o 0; all counters and the blink phase 0.
- Register map (byte offsets, word aligned, addr[1:0] ignored):
  - 0x00 VALUE: [3:0] static level per LED. RW.
  - 0x04 MODE: 2 bits per LED at [2i+1:2i]. 00 = static, 01 = blink, 10 = PWM, 11 = forced off. RW.
  - 0x08 BLINK_DIV: [31:0] blink half-period in clocks; 0 behaves as 1. RW.
  - 0x0C DUTY: [8i+7:8i] PWM duty for LED i. RW.
  - 0x10 STATUS: [31:16] VERSION, [0] blink phase. RO.
  - 0x14-0x1C: reads return 0; writes are ignored. Response is OKAY.
- Unused bits read as 0. WSTRB is honoured per byte; wstrb = 0 changes nothing but still produces a B response.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready is 1 in W_IDLE and W_HAVE_W. wready is 1 in W_IDLE and W_HAVE_AW.
  - AW and W may arrive in the same cycle or in either order. When both are held, the register write commits on that edge and the FSM enters W_RESP with bvalid = 1.
  - bvalid holds until bready; then return to W_IDLE. There is never more than one outstanding write.
- Read FSM states: R_IDLE (arready = 1), R_DATA (rvalid = 1).
  - rdata is captured on the AR handshake edge and held stable until rready.
  - Reads and writes proceed independently. A read in the same cycle as a write to the same register returns the old value.
- Blink:
  - blink_cnt counts 0..max(BLINK_DIV,1)-1. On the wrap, blink_phase toggles.
  - A write to BLINK_DIV clears blink_cnt and blink_phase on the commit edge.
- PWM:
  - An 8-bit pwm_cnt advances once per PWM_PRESCALE clocks and wraps 255->0.
  - LED i is on when pwm_cnt < DUTY[i]. Duty 0 is always off; duty 255 is on 255 of every 256 steps.
- Output: led_4bits_tri_o[i] is registered from a mux selected by MODE[i]: VALUE[i], VALUE[i] & blink_phase, PWM compare, or 0.
- Latency: a VALUE write in static mode appears on led_4bits_tri_o exactly 1 clock after the commit edge.
- Reset mid-transaction: the pending transfer is dropped, bvalid/rvalid go low on the next edge, and the master must retry.

Decomposition:
- Package axi_led_pkg holds:
  - register offset localparams;
  - the mode encoding enum (MODE_STATIC, MODE_BLINK, MODE_PWM, MODE_OFF);
  - the write and read FSM state typedefs;
  - RESP_OKAY.
- One sub-module, led_pattern_gen, holds the blink and PWM counters plus the per-LED output mux. Its inputs are VALUE, MODE, BLINK_DIV, DUTY and a blink_div_wr pulse; its outputs are leds[3:0] and blink_phase.
- The top level holds the AXI FSMs and the register file.

Test Plan:
- Write 0x00 = 0xFFFFFFFF (wstrb 0xF) with MODE = 0 -> read 0x00 returns 0x0000000F; led_4bits_tri_o = 4'hF one clock after commit.
- AW presented 3 cycles before W; bready held low 5 cycles -> exactly one B, OKAY; bvalid stays high until bready; register updated once.
- MODE = 0x01, VALUE = 0x1, BLINK_DIV = 4 -> LED0 toggles every 4 clocks; STATUS[0] tracks the phase; LEDs 1-3 = 0.
- MODE = 0xAA, DUTY = 0xFF_80_40_00, PWM_PRESCALE = 1 -> per 256-step window LED0 is high 0 steps, LED1 64, LED2 128, LED3 255.
- Write 0x04 with wstrb = 0 -> MODE unchanged, B OKAY. Read 0x1C -> rdata 0, rresp OKAY. Read 0x10 -> rdata[31:16] = 0x0100.
- Assert areset for 1 cycle while bvalid = 1 and the LEDs are blinking -> next edge: bvalid = 0, all registers 0, led_4bits_tri_o = 0.
